pwm_duty_ramp: RTL and testbench

Soft-start duty-cycle sequencer placed directly upstream of the PWM generator. It accepts a target duty cycle over a valid/ready handshake. It then steps its `duty_cycle` output toward that target by a programmable increment, changing it only on PWM period boundaries so the downstream PWM never sees a mid-period duty change. It removes abrupt duty jumps (inrush, LED flicker, motor torque steps) without changing the PWM block.

---
 rtl/pwm_duty_ramp_if.sv | 26 ++
 rtl/pwm_duty_ramp.sv | 149 ++++++++++++++
 tb/tb_pwm_duty_ramp.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_duty_ramp_if.sv
// Target handshake between a duty-cycle source and the soft-start ramp.
// The source (master) offers a target duty and step size; the ramp (slave)
// signals when it can take a new target.
`timescale 1ns/1ps
interface pwm_duty_ramp_if #(
  parameter int WIDTH = 8
) ();
  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] tgt_duty;
  logic [WIDTH-1:0] step;

  modport master (
    output tgt_valid,
    output tgt_duty,
    output step,
    input  tgt_ready
  );

  modport slave (
    input  tgt_valid,
    input  tgt_duty,
    input  step,
    output tgt_ready
  );
endinterface

// File: rtl/pwm_duty_ramp.sv
// Soft-start duty-cycle sequencer sitting in front of a PWM generator.
// Accepts a target duty, then walks duty_cycle toward it by a fixed step,
// updating only on the PWM period wrap so the PWM never sees a mid-period
// duty change.
`timescale 1ns/1ps
module pwm_duty_ramp #(
  parameter int WIDTH    = 8,
  parameter int PERIOD   = 256,
  parameter int STEP_DIV = 1
) (
  input  logic              clkin,
  input  logic              reset,
  pwm_duty_ramp_if.slave    tgt,
  output logic [WIDTH-1:0]  duty_cycle,
  output logic              period_tick,
  output logic              busy,
  output logic              done
);

  localparam int PCNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int DCNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PERIOD - 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(STEP_DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  logic [PCNT_W-1:0] pcnt_reg, pcnt_next;
  logic              tick_reg, tick_next;
  logic [DCNT_W-1:0] dcnt_reg, dcnt_next;
  logic [WIDTH-1:0]  duty_reg, duty_next;
  logic [WIDTH-1:0]  target_reg, target_next;
  logic [WIDTH-1:0]  stp_reg, stp_next;
  logic              done_reg, done_next;

  logic              accept;
  logic              step_evt;
  logic              dir_up;
  logic [WIDTH:0]    target_ext;
  logic [WIDTH:0]    duty_ext;
  logic [WIDTH:0]    stp_ext;
  logic [WIDTH:0]    diff;
  logic [WIDTH:0]    moved;

  // Free-running period counter; the tick is registered so it is high
  // exactly while pcnt_reg sits on the last cycle of the period.
  always_comb begin
    pcnt_next = (pcnt_reg == PCNT_LAST) ? '0 : pcnt_reg + PCNT_W'(1);
    tick_next = (pcnt_next == PCNT_LAST);
  end

  // Period counter and tick registers.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      pcnt_reg <= '0;
      tick_reg <= 1'b0;
    end else begin
      pcnt_reg <= pcnt_next;
      tick_reg <= tick_next;
    end
  end

  assign accept   = tgt.tgt_valid && (state_reg == IDLE);
  assign step_evt = tick_reg && (dcnt_reg == DCNT_LAST);

  // Distance and candidate next duty, one bit wider than the duty so the
  // comparison against the step can never wrap.
  always_comb begin
    target_ext = {1'b0, target_reg};
    duty_ext   = {1'b0, duty_reg};
    stp_ext    = {1'b0, stp_reg};
    dir_up     = (target_reg >= duty_reg);
    diff       = dir_up ? (target_ext - duty_ext) : (duty_ext - target_ext);
    moved      = dir_up ? (duty_ext + stp_ext) : (duty_ext - stp_ext);
  end

  // Next-state logic: divider bookkeeping, target capture and step landing.
  always_comb begin
    state_next  = state_reg;
    dcnt_next   = dcnt_reg;
    duty_next   = duty_reg;
    target_next = target_reg;
    stp_next    = stp_reg;
    done_next   = 1'b0;

    if (tick_reg) begin
      dcnt_next = (dcnt_reg == DCNT_LAST) ? '0 : dcnt_reg + DCNT_W'(1);
    end

    unique case (state_reg)
      IDLE: begin
        if (accept) begin
          // Restart the divider so the first step is a full STEP_DIV
          // periods away, counted from the next tick.
          dcnt_next = '0;
          if (tgt.tgt_duty != duty_reg) begin
            state_next  = RAMP;
            target_next = tgt.tgt_duty;
            stp_next    = (tgt.step == '0) ? WIDTH'(1) : tgt.step;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      RAMP: begin
        if (step_evt) begin
          if (diff <= stp_ext) begin
            // Final step lands exactly on the target: no overshoot, no wrap.
            duty_next  = target_reg;
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            duty_next = WIDTH'(moved);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Ramp state registers.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      dcnt_reg   <= '0;
      duty_reg   <= '0;
      target_reg <= '0;
      stp_reg    <= '0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      dcnt_reg   <= dcnt_next;
      duty_reg   <= duty_next;
      target_reg <= target_next;
      stp_reg    <= stp_next;
      done_reg   <= done_next;
    end
  end

  assign tgt.tgt_ready = (state_reg == IDLE);
  assign busy          = (state_reg == RAMP);
  assign duty_cycle    = duty_reg;
  assign period_tick   = tick_reg;
  assign done          = done_reg;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Scoreboard bench for pwm_duty_ramp: stimulus pushes expected duty/done
// events, per-DUT monitors pop and compare whenever duty changes or done
// pulses. A second instance (PERIOD=16, STEP_DIV=3) covers the divider.
`timescale 1ns/1ps
module tb_pwm_duty_ramp;

  typedef struct {
    logic [7:0] duty;
    logic       done;
    int         gap;    // cycles since previous duty change, 0 = unchecked
  } exp_t;

  logic clk;
  logic rst_n;

  logic [7:0] duty, duty3;
  logic       tick, tick3, busy, busy3, done, done3;

  exp_t q_main[$];
  exp_t q_div[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  pwm_duty_ramp_if #(.WIDTH(8)) tgt_if ();
  pwm_duty_ramp_if #(.WIDTH(8)) tgt3_if ();

  pwm_duty_ramp #(.WIDTH(8), .PERIOD(256), .STEP_DIV(1)) u_dut (
    .clkin       (clk),
    .reset       (rst_n),
    .tgt         (tgt_if.slave),
    .duty_cycle  (duty),
    .period_tick (tick),
    .busy        (busy),
    .done        (done)
  );

  pwm_duty_ramp #(.WIDTH(8), .PERIOD(16), .STEP_DIV(3)) u_dut3 (
    .clkin       (clk),
    .reset       (rst_n),
    .tgt         (tgt3_if.slave),
    .duty_cycle  (duty3),
    .period_tick (tick3),
    .busy        (busy3),
    .done        (done3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [7:0] d, input logic dn, input int g);
    exp_t e;
    e.duty = d;
    e.done = dn;
    e.gap  = g;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end else begin
      $display("[TB] ok %s = %0d", name, act);
    end
  endtask

  // Main-DUT monitor: compares every duty change / done pulse.
  initial begin
    logic [7:0] prev_duty;
    logic       prev_tick;
    int         cyc, last_chg;
    exp_t       e;
    prev_duty = 0; prev_tick = 0; cyc = 0; last_chg = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_duty = 0;
        prev_tick = 0;
      end else begin
        if (done || duty != prev_duty) begin
          n_tests++;
          if (q_main.size() == 0) begin
            n_fail++;
            $display("FAIL main_unexpected: duty=%0d done=%0b with nothing expected", duty, done);
          end else begin
            e = q_main.pop_front();
            if (duty !== e.duty || done !== e.done || busy !== !e.done) begin
              n_fail++;
              $display("FAIL main_event: got duty=%0d done=%0b busy=%0b, expected duty=%0d done=%0b busy=%0b",
                       duty, done, busy, e.duty, e.done, !e.done);
            end else begin
              $display("[TB] main event duty=%0d done=%0b busy=%0b", duty, done, busy);
            end
            if (e.gap != 0) begin
              n_tests++;
              if (cyc - last_chg != e.gap) begin
                n_fail++;
                $display("FAIL main_gap: got %0d cycles, expected %0d", cyc - last_chg, e.gap);
              end
            end
          end
          if (duty != prev_duty) begin
            n_tests++;
            if (prev_tick !== 1'b1) begin
              n_fail++;
              $display("FAIL main_align: duty changed to %0d, prior tick=%0b expected 1", duty, prev_tick);
            end
            last_chg = cyc;
          end
        end
        prev_duty = duty;
        prev_tick = tick;
      end
    end
  end

  // Divider-DUT monitor.
  initial begin
    logic [7:0] prev_duty;
    logic       prev_tick;
    int         cyc, last_chg;
    exp_t       e;
    prev_duty = 0; prev_tick = 0; cyc = 0; last_chg = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_duty = 0;
        prev_tick = 0;
      end else begin
        if (done3 || duty3 != prev_duty) begin
          n_tests++;
          if (q_div.size() == 0) begin
            n_fail++;
            $display("FAIL div_unexpected: duty=%0d done=%0b with nothing expected", duty3, done3);
          end else begin
            e = q_div.pop_front();
            if (duty3 !== e.duty || done3 !== e.done || busy3 !== !e.done) begin
              n_fail++;
              $display("FAIL div_event: got duty=%0d done=%0b busy=%0b, expected duty=%0d done=%0b busy=%0b",
                       duty3, done3, busy3, e.duty, e.done, !e.done);
            end else begin
              $display("[TB] div event duty=%0d done=%0b busy=%0b", duty3, done3, busy3);
            end
            if (e.gap != 0) begin
              n_tests++;
              if (cyc - last_chg != e.gap) begin
                n_fail++;
                $display("FAIL div_gap: got %0d cycles, expected %0d", cyc - last_chg, e.gap);
              end
            end
          end
          if (duty3 != prev_duty) begin
            n_tests++;
            if (prev_tick !== 1'b1) begin
              n_fail++;
              $display("FAIL div_align: duty changed to %0d, prior tick=%0b expected 1", duty3, prev_tick);
            end
            last_chg = cyc;
          end
        end
        prev_duty = duty3;
        prev_tick = tick3;
      end
    end
  end

  // Present a target and hold valid until the accepting edge has passed.
  task automatic send(input bit sel, input logic [7:0] d, input logic [7:0] s);
    int k;
    bit r;
    @(posedge clk); #1;
    if (sel) begin
      tgt3_if.tgt_valid = 1'b1; tgt3_if.tgt_duty = d; tgt3_if.step = s;
    end else begin
      tgt_if.tgt_valid = 1'b1; tgt_if.tgt_duty = d; tgt_if.step = s;
    end
    k = 0;
    r = 1'b0;
    while (!r && k < 2000) begin
      @(negedge clk);
      r = sel ? tgt3_if.tgt_ready : tgt_if.tgt_ready;
      @(posedge clk); #1;
      k++;
    end
    tgt_if.tgt_valid  = 1'b0;
    tgt3_if.tgt_valid = 1'b0;
    if (!r) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: target %0d not accepted in %0d cycles", d, k);
    end else begin
      $display("[TB] sent target=%0d step=%0d to %s", d, s, sel ? "div" : "main");
    end
  endtask

  // Wait until a DUT is idle and all its expected events are consumed.
  task automatic wait_idle(input bit sel, input int budget);
    int k;
    k = 0;
    while (k < budget &&
           (sel ? (q_div.size() != 0 || busy3) : (q_main.size() != 0 || busy))) begin
      @(negedge clk);
      k++;
    end
    #1;
    if (k >= budget) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_timeout: %s still busy after %0d cycles, %0d events pending",
               sel ? "div" : "main", k, sel ? q_div.size() : q_main.size());
    end
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    tgt_if.tgt_valid = 0;  tgt_if.tgt_duty = 0;  tgt_if.step = 0;
    tgt3_if.tgt_valid = 0; tgt3_if.tgt_duty = 0; tgt3_if.step = 0;

    // Reset held with random inputs.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      tgt_if.tgt_valid = 1'($urandom);
      tgt_if.tgt_duty  = 8'($urandom);
      tgt_if.step      = 8'($urandom);
    end
    @(negedge clk);
    check("rst_duty", duty, 0);
    check("rst_tick", tick, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", tgt_if.tgt_ready, 1);
    tgt_if.tgt_valid = 1'b0;
    rst_n = 1'b1;

    // pcnt runs 0..255 from release; tick is high while pcnt==255.
    k = 0;
    while (!tick && k < 600) begin
      @(posedge clk); #1;
      k++;
    end
    check("first_tick_edges", k, 255);

    // Ramp up 0 -> 64 by 16.
    q_main.push_back(mk(8'd16, 1'b0, 0));
    q_main.push_back(mk(8'd32, 1'b0, 256));
    q_main.push_back(mk(8'd48, 1'b0, 256));
    q_main.push_back(mk(8'd64, 1'b1, 256));
    send(1'b0, 8'd64, 8'd16);
    check("accept_busy", busy, 1);
    check("accept_ready", tgt_if.tgt_ready, 0);
    wait_idle(1'b0, 3000);

    // Ramp down 64 -> 10 by 20, landing without undershoot.
    q_main.push_back(mk(8'd44, 1'b0, 0));
    q_main.push_back(mk(8'd24, 1'b0, 256));
    q_main.push_back(mk(8'd10, 1'b1, 256));
    send(1'b0, 8'd10, 8'd20);
    wait_idle(1'b0, 3000);

    // 10 -> 250 in one step, then 250 -> 255 with a huge step: no wrap.
    q_main.push_back(mk(8'd250, 1'b1, 0));
    send(1'b0, 8'd250, 8'd240);
    wait_idle(1'b0, 3000);
    q_main.push_back(mk(8'd255, 1'b1, 0));
    send(1'b0, 8'd255, 8'd200);
    wait_idle(1'b0, 3000);

    // Down to 5, then step 0 behaves as 1: 6, 7, 8.
    q_main.push_back(mk(8'd5, 1'b1, 0));
    send(1'b0, 8'd5, 8'd250);
    wait_idle(1'b0, 3000);
    q_main.push_back(mk(8'd6, 1'b0, 0));
    q_main.push_back(mk(8'd7, 1'b0, 256));
    q_main.push_back(mk(8'd8, 1'b1, 256));
    send(1'b0, 8'd8, 8'd0);
    // Valid pulsed mid-ramp must be ignored.
    repeat (20) @(posedge clk);
    #1;
    tgt_if.tgt_valid = 1'b1; tgt_if.tgt_duty = 8'd200; tgt_if.step = 8'd50;
    repeat (3) @(posedge clk);
    #1;
    check("bp_ready_low", tgt_if.tgt_ready, 0);
    tgt_if.tgt_valid = 1'b0;
    wait_idle(1'b0, 3000);

    // Target equal to current duty: done next cycle, no ramp.
    q_main.push_back(mk(8'd8, 1'b1, 0));
    send(1'b0, 8'd8, 8'd3);
    check("eq_busy", busy, 0);
    check("eq_ready", tgt_if.tgt_ready, 1);
    @(posedge clk); #1;
    check("eq_busy_later", busy, 0);
    check("eq_duty", duty, 8);
    wait_idle(1'b0, 3000);

    // Back to 0, then reset in the middle of a 0 -> 200 ramp.
    q_main.push_back(mk(8'd0, 1'b1, 0));
    send(1'b0, 8'd0, 8'd255);
    wait_idle(1'b0, 3000);
    q_main.push_back(mk(8'd32, 1'b0, 0));
    q_main.push_back(mk(8'd64, 1'b0, 256));
    q_main.push_back(mk(8'd96, 1'b0, 256));
    send(1'b0, 8'd200, 8'd32);
    k = 0;
    while (duty != 8'd96 && k < 3000) begin
      @(posedge clk); #1;
      k++;
    end
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_duty", duty, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", tgt_if.tgt_ready, 1);
    check("midrst_pending", q_main.size(), 0);
    @(negedge clk); #2;
    rst_n = 1'b1;

    // Fresh ramp after reset starts from 0.
    q_main.push_back(mk(8'd20, 1'b1, 0));
    send(1'b0, 8'd20, 8'd20);
    wait_idle(1'b0, 3000);

    // Divider instance: one step every 3 periods of 16 cycles.
    q_div.push_back(mk(8'd2, 1'b0, 0));
    q_div.push_back(mk(8'd4, 1'b0, 48));
    q_div.push_back(mk(8'd6, 1'b1, 48));
    send(1'b1, 8'd6, 8'd2);
    check("div_accept_busy", busy3, 1);
    wait_idle(1'b1, 1000);

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time bound, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
